// File: rtl/vga_scroll_sequencer_pkg.sv
// vga_pkg: register offsets, STATUS bit positions, FSM states and the scroll step helper.
package vga_pkg;
  localparam logic [1:0] REG_SCROLL  = 2'd0;
  localparam logic [1:0] REG_AUTO    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;
  localparam int ST_PENDING   = 0;
  localparam int ST_AUTO      = 1;
  localparam int ST_IRQ       = 2;
  localparam int ST_VBLANK    = 3;
  localparam int ST_FRAME_LSB = 16;
  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_CANCEL  = 1;
  typedef enum logic {IDLE, AUTO_RUN} state_t;
  // Row and column wrap independently in 5 bits, so a step of 31 moves by -1.
  function automatic logic [9:0] scroll_step(logic [9:0] s, logic [4:0] dy, logic [4:0] dx);
    logic [4:0] r;
    logic [4:0] c;
    r = s[9:5] + dy;
    c = s[4:0] + dx;
    return {r, c};
  endfunction
endpackage

// File: rtl/vga_scroll_sequencer_if.sv
// vga_scroll_sequencer_if: CPU register bus between the processor and the scroll sequencer.
interface vga_scroll_sequencer_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [1:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  modport master (output cs, read, write, address, data_in, input data_out);
  modport slave  (input cs, read, write, address, data_in, output data_out);
endinterface

// File: rtl/vga_scroll_sequencer_vblank_edge_sync.sv
// vblank_edge_sync: synchronises the VGA vertical-visible flag and pulses on its falling edge.
module vblank_edge_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic async_i,
  output logic synced_o,
  output logic fall_o
);
  logic [2:0] sync_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) sync_q <= '1;
    else sync_q <= {sync_q[1:0], async_i};
  assign synced_o = sync_q[1];
  assign fall_o   = sync_q[2] & ~sync_q[1];
endmodule

// File: rtl/vga_scroll_sequencer.sv
// vga_scroll_sequencer: commits CPU scroll writes and per-frame auto-scroll steps at vblank start.
module vga_scroll_sequencer
  import vga_pkg::*;
#(
  parameter int FRAME_COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   v_visible_async,
  vga_scroll_sequencer_if.slave  bus,
  output logic [9:0]             scroll_out,
  output logic                   irq
);
  logic                         v_visible;
  logic                         vblank;
  logic [9:0]                   scroll_q, scroll_d;
  logic                         pend_q, pend_d;
  logic [9:0]                   pend_val_q, pend_val_d;
  state_t                       state_q, state_d;
  logic [4:0]                   dy_q, dy_d, dx_q, dx_d;
  logic [7:0]                   rem_q, rem_d;
  logic [FRAME_COUNT_WIDTH-1:0] frame_q, frame_d;
  logic                         irq_pend_q, irq_pend_d;
  logic                         irq_en_q, irq_en_d;
  logic [31:0]                  dout_q, dout_d;
  logic                         sc_wr, au_wr, st_wr, ct_wr, cancel;
  logic [31:0]                  status, rdata;
  vblank_edge_sync u_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .async_i  (v_visible_async),
    .synced_o (v_visible),
    .fall_o   (vblank)
  );
  assign sc_wr  = bus.cs & bus.write & (bus.address == REG_SCROLL);
  assign au_wr  = bus.cs & bus.write & (bus.address == REG_AUTO);
  assign st_wr  = bus.cs & bus.write & (bus.address == REG_STATUS);
  assign ct_wr  = bus.cs & bus.write & (bus.address == REG_CONTROL);
  assign cancel = ct_wr & bus.data_in[CTRL_CANCEL];
  always_comb begin
    status                                           = '0;
    status[ST_PENDING]                               = pend_q;
    status[ST_AUTO]                                  = state_q == AUTO_RUN;
    status[ST_IRQ]                                   = irq_pend_q;
    status[ST_VBLANK]                                = ~v_visible;
    status[ST_FRAME_LSB +: 16]                       = 16'(frame_q);
  end
  assign rdata = bus.address == REG_SCROLL ? {20'b0, scroll_q, 2'b0} :
                 bus.address == REG_AUTO   ? {8'b0, rem_q, 6'b0, dy_q, dx_q} :
                 bus.address == REG_STATUS ? status : {31'b0, irq_en_q};
  always_comb begin
    scroll_d   = scroll_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    state_d    = state_q;
    dy_d       = dy_q;
    dx_d       = dx_q;
    rem_d      = rem_q;
    frame_d    = frame_q;
    irq_pend_d = irq_pend_q;
    irq_en_d   = irq_en_q;
    dout_d     = bus.cs && bus.read ? rdata : dout_q;
    // A manual value (pending or written this cycle) always beats the auto step.
    if (vblank) begin
      frame_d = frame_q + 1'b1;
      if (sc_wr || pend_q) begin
        scroll_d = sc_wr ? bus.data_in[11:2] : pend_val_q;
        pend_d   = 1'b0;
        state_d  = IDLE;
        rem_d    = '0;
      end else if (state_q == AUTO_RUN && !au_wr && !cancel) begin
        scroll_d = scroll_step(scroll_q, dy_q, dx_q);
        rem_d    = rem_q - 8'd1;
        state_d  = rem_q == 8'd1 ? IDLE : AUTO_RUN;
      end
    end
    if (sc_wr) begin
      pend_val_d = bus.data_in[11:2];
      pend_d     = ~vblank;
    end
    if (au_wr) begin
      dy_d    = bus.data_in[9:5];
      dx_d    = bus.data_in[4:0];
      rem_d   = bus.data_in[23:16];
      state_d = bus.data_in[23:16] != 8'd0 ? AUTO_RUN : IDLE;
    end
    if (st_wr && bus.data_in[ST_IRQ]) irq_pend_d = 1'b0;
    if (vblank && irq_en_q) irq_pend_d = 1'b1;
    if (ct_wr) begin
      irq_en_d = bus.data_in[CTRL_IRQ_EN];
      if (bus.data_in[CTRL_CANCEL]) begin
        state_d = IDLE;
        rem_d   = '0;
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      scroll_q   <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      state_q    <= IDLE;
      dy_q       <= '0;
      dx_q       <= '0;
      rem_q      <= '0;
      frame_q    <= '0;
      irq_pend_q <= 1'b0;
      irq_en_q   <= 1'b0;
      dout_q     <= '0;
    end else begin
      scroll_q   <= scroll_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      state_q    <= state_d;
      dy_q       <= dy_d;
      dx_q       <= dx_d;
      rem_q      <= rem_d;
      frame_q    <= frame_d;
      irq_pend_q <= irq_pend_d;
      irq_en_q   <= irq_en_d;
      dout_q     <= dout_d;
    end
  assign bus.data_out = dout_q;
  assign scroll_out   = scroll_q;
  assign irq          = irq_pend_q & irq_en_q;
endmodule
